// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg
// Shared definitions for the adder arbiter: the FSM state encoding and the
// default operand width and requester count.
package adder_arb_pkg;

  localparam int N_DEF    = 32;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    CAPT = 2'b10,
    RESP = 2'b11
  } state_t;

endpackage

// File: rtl/fa32bit.sv
// fa32bit
// Combinational N-bit adder with carry-in and carry-out.
// Ports:
//   a, b  in  N  operands
//   cin   in  1  carry-in
//   s     out N  sum
//   cout  out 1  carry-out
module fa32bit
  import adder_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/rr_picker.sv
// rr_picker
// Purely combinational round-robin picker. It finds the first set request bit,
// scanning upward from rr_ptr and wrapping from NREQ-1 back to 0.
// Ports:
//   req_valid  in  NREQ  pending requests
//   rr_ptr     in  PW    highest-priority index for this pick
//   winner     out NREQ  one-hot winner (0 when nothing is pending)
//   winner_idx out PW    encoded winner index (0 when nothing is pending)
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic [PW-1:0]   winner_idx
);

  int          pos;
  logic [PW-1:0] pos_idx;

  // Walk from the farthest offset down to offset 0, so the last hit written
  // is the one closest to rr_ptr.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    pos        = 0;
    pos_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      pos_idx = PW'(pos);
      if (req_valid[pos_idx]) begin
        winner          = '0;
        winner[pos_idx] = 1'b1;
        winner_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Shares one fa32bit adder among NREQ requesters with round-robin priority.
// One operation is in flight at a time: accept, execute, capture, respond.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting; accepts the round-robin winner when any request is up
//   EXEC  | latched operands are driving the adder
//   CAPT  | adder sum/carry registered into res_q/cout_q
//   RESP  | one-cycle result pulse to grant_id; pointer moves past it
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready per-requester handshake (ready is one-hot)
//   req_a/req_b/req_cin packed per-requester operands
//   rsp_valid           one-hot one-cycle result strobe
//   rsp_s/rsp_cout      result, driven only while rsp_valid is nonzero
//   busy                high outside IDLE
//   grant_id            index of the requester in service
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_s,
  output logic              rsp_cout,
  output logic              busy,
  output logic [PW-1:0]     grant_id
);

  state_t          state, state_nx;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] winner;
  logic [PW-1:0]   winner_idx;
  logic            accept;
  logic [N-1:0]    a_q, b_q, res_q;
  logic            cin_q, cout_q;
  logic [N-1:0]    sum;
  logic            sum_cout;

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr),
    .winner     (winner),
    .winner_idx (winner_idx)
  );

  fa32bit #(.N(N)) u_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .s    (sum),
    .cout (sum_cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid) state_nx = EXEC;
      EXEC:    state_nx = CAPT;
      CAPT:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && (|req_valid);

  // Gated by rst_n so nothing looks accepted during the reset cycle itself.
  assign req_ready = (rst_n && state == IDLE) ? winner : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    rsp_valid = '0;
    rsp_s     = '0;
    rsp_cout  = 1'b0;
    if (state == RESP) begin
      rsp_valid[grant_id] = 1'b1;
      rsp_s               = res_q;
      rsp_cout            = cout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q      <= req_a[winner_idx*N +: N];
        b_q      <= req_b[winner_idx*N +: N];
        cin_q    <= req_cin[winner_idx];
        grant_id <= winner_idx;
      end
      if (state == CAPT) begin
        res_q  <= sum;
        cout_q <= sum_cout;
      end
      if (state == RESP) begin
        rr_ptr <= (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_s;
  logic              rsp_cout;
  logic              busy;
  logic [1:0]        grant_id;

  typedef struct {
    int         id;
    logic [N-1:0] s;
    logic       cout;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  logic [N-1:0] op_a[NREQ];
  logic [N-1:0] op_b[NREQ];
  logic        op_cin[NREQ];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int prev_acc = 0;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NREQ-1:0] onehot(int id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(int id, logic [N-1:0] a, logic [N-1:0] b, logic cin);
    op_a[id]           = a;
    op_b[id]           = b;
    op_cin[id]         = cin;
    req_a[id*N +: N]   = a;
    req_b[id*N +: N]   = b;
    req_cin[id]        = cin;
  endtask

  // Waits for a handshake, checks the winner, and pushes the expected result.
  // Returns at the falling edge inside EXEC.
  task automatic wait_accept(int id, bit drop);
    bit          ok;
    logic [N:0]  full;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((req_ready & req_valid) != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", 64'(ok), 64'd1);
    if (ok) begin
      full = {1'b0, op_a[id]} + {1'b0, op_b[id]} + (N+1)'(op_cin[id]);
      check("ready_onehot", 64'(req_ready), 64'(onehot(id)));
      sb.push_back('{id: id, s: full[N-1:0], cout: full[N], cyc: cyc + 3});
      prev_acc = last_acc;
      last_acc = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      check("grant_id", 64'(grant_id), 64'(id));
      check("busy_exec", 64'(busy), 64'd1);
      if (drop) req_valid[id] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  // Response monitor: every pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rsp_valid !== '0) begin
      check("rsp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(onehot(e.id)));
        check("rsp_s", 64'(rsp_s), 64'(e.s));
        check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        check("rsp_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    set_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    set_op(3, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Reset with all requesters already valid
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_s", 64'(rsp_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: order 0,1,2,3,0, accepts 4 cycles apart
    wait_accept(0, 1'b0);
    wait_accept(1, 1'b0);
    check("spacing_01", 64'(last_acc - prev_acc), 64'd4);
    wait_accept(2, 1'b0);
    check("spacing_12", 64'(last_acc - prev_acc), 64'd4);
    wait_accept(3, 1'b0);
    check("spacing_23", 64'(last_acc - prev_acc), 64'd4);
    wait_accept(0, 1'b0);
    check("spacing_30", 64'(last_acc - prev_acc), 64'd4);
    req_valid = '0;
    drain();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_grant_hold", 64'(grant_id), 64'd0);

    // Single request and carry-out
    req_valid = 4'b0001;
    wait_accept(0, 1'b1);
    drain();
    req_valid = 4'b0100;
    wait_accept(2, 1'b1);
    drain();

    // Pointer wrap: serve 3, then 1 beats 3
    req_valid = 4'b1000;
    wait_accept(3, 1'b1);
    drain();
    req_valid = 4'b1010;
    wait_accept(1, 1'b1);
    req_valid = '0;
    drain();

    // Reset mid-operation in CAPT; pointer must restart at 0
    req_valid = 4'b1000;
    wait_accept(3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_grant", 64'(grant_id), 64'd0);
    check("midrst_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 4'b1010;
    wait_accept(1, 1'b1);
    req_valid = '0;
    drain();

    // Withdraw during EXEC: requester 1 is ignored and never served
    set_op(0, 32'hDEAD_BEEF, 32'h2152_4111, 1'b1);
    req_valid = 4'b0001;
    wait_accept(0, 1'b1);
    req_valid[1] = 1'b1;
    #1;
    check("exec_ready_ignored", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    check("capt_ready", 64'(req_ready), 64'd0);
    drain();
    check("withdraw_ready", 64'(req_ready), 64'd0);
    check("withdraw_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin controller that shares one `fa32bit` adder instance among `NREQ` requesters. Each requester presents an operand pair and carry-in with a valid/ready handshake. The arbiter grants one request at a time, latches its operands and drives them into the adder. It then captures `s`/`cout` and returns the result to the winning requester as a one-cycle response pulse. It sits between the requesting datapath blocks and the single shared adder.

## Interface
- `N`, 32: operand/result width; must match the adder instance width.
- `NREQ`, 4: number of requesters, at least 2.
- `PW`, $clog2(NREQ): pointer/grant-index width (derived).

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  NREQ: bit i set means requester i has an operation pending.
- `req_ready`  out  NREQ: one-hot accept; a transfer occurs when `req_valid[i] && req_ready[i]` at a rising edge.
- `req_a`  in  NREQ*N: operand A; requester i occupies bits `[i*N +: N]`.
- `req_b`  in  NREQ*N: operand B, packed the same way as `req_a`.
- `req_cin`  in  NREQ: carry-in per requester.
- `rsp_valid`  out  NREQ: one-hot, one-cycle result strobe to the granted requester.
- `rsp_s`  out  N: sum; valid only while `rsp_valid` is nonzero.
- `rsp_cout`  out  1: carry-out; valid only while `rsp_valid` is nonzero.
- `busy`  out  1: high in every state except IDLE.
- `grant_id`  out  PW: index of the requester currently in service; holds its last value while in IDLE.

## Operation
- FSM has four states:
  - IDLE: if any `req_valid` bit is set, pick the winner and go to EXEC; otherwise stay in IDLE.
  - EXEC: always go to CAPT.
  - CAPT: always go to RESP.
  - RESP: always go to IDLE.
- Winner selection: the first set `req_valid` bit found scanning upward from `rr_ptr`, wrapping from NREQ-1 to 0.
- `req_ready` is combinational. It equals the one-hot winner while in IDLE and is 0 in all other states.
- On accept:
  - Latch `a_q`, `b_q`, `cin_q` from the winner's slice.
  - Latch `grant_id`.
- The adder's `a`, `b` and `cin` are always driven from `a_q`, `b_q`, `cin_q`, which stay stable from EXEC through RESP.
- In CAPT, the adder's `s`/`cout` are registered into `res_q`/`cout_q`.
- In RESP:
  - `rsp_valid[grant_id]` = 1.
  - `rsp_s` = `res_q` and `rsp_cout` = `cout_q`.
  - `rr_ptr` is set to `grant_id + 1`, wrapping to 0 after NREQ-1.
- Arithmetic: {`rsp_cout`, `rsp_s`} = `a` + `b` + `cin` over N+1 bits, with no truncation of the carry.
- Boundary conditions:
  - A requester that drops `req_valid` before being granted is legal; no state is kept for it.
  - `req_valid` bits that change during EXEC, CAPT or RESP are ignored.
  - A requester may reassert `req_valid` in the same cycle its `rsp_valid` pulses. It competes in the next IDLE cycle and has the lowest priority there, because `rr_ptr` has already moved past it.
  - Responses have no backpressure; the consumer must sample `rsp_valid` on the cycle it is high.
- Reset (`rst_n` = 0 at a rising edge), including mid-operation:
  - state goes to IDLE.
  - `rr_ptr` = 0 and `grant_id` = 0.
  - `a_q`, `b_q`, `cin_q`, `res_q`, `cout_q` = 0.
  - All outputs are 0.
  - An in-flight operation is discarded and no response is issued.

## Timing
- Accept edge T (IDLE, handshake complete):
  - EXEC covers cycle T+1.
  - CAPT covers cycle T+2.
  - `rsp_valid` is high during cycle T+3 only.
- Latency is 3 cycles from accept to response.
- Back-to-back throughput: one operation every 4 cycles.
- Operands reach the adder one full cycle before capture. This tolerates an adder that is either combinational or registered with one-cycle latency.
- Outputs after reset: `req_ready` = 0 only while `rst_n` is low; all other outputs are 0 until the first accept.

## Structure
- Package `adder_arb_pkg` holds:
  - state encodings: IDLE = 2'b00, EXEC = 2'b01, CAPT = 2'b10, RESP = 2'b11;
  - default `N` and `NREQ`.
- Sub-module `rr_picker` (inputs: `req_valid`, `rr_ptr`; outputs: one-hot winner plus encoded index) is purely combinational and reused by other arbiters.
- A single `fa32bit` instance lives inside `adder_arbiter`.

## Test plan
- Single request: requester 0 with a = 32'h0000_0005, b = 32'h0000_0003, cin = 0 → accepted at T; `rsp_valid` = 4'b0001 at T+3; `rsp_s` = 32'h8, `rsp_cout` = 0.
- Carry-out: requester 2 with a = 32'hFFFF_FFFF, b = 32'h0000_0001, cin = 1 → `rsp_s` = 32'h1, `rsp_cout` = 1, `rsp_valid` = 4'b0100.
- Contention: all four requesters held valid from reset → grant order 0, 1, 2, 3, 0; accepts 4 cycles apart; each response routed to the matching bit.
- Pointer wrap: after serving requester 3, requesters 1 and 3 both valid → requester 1 wins.
- Reset mid-operation: `rst_n` low in CAPT → no `rsp_valid` pulse, `busy` = 0 and `grant_id` = 0 next cycle; a new request afterwards is served normally, starting from pointer 0.
- Withdraw and ignore: requester 1 raises and drops `req_valid` while the FSM is in EXEC → no grant or response for requester 1 afterwards.
